// File: rtl/ysyx_22050078_store_buffer.sv
// Store buffer: aligns and byte-masks stores, queues them in order,
// drains one per memory handshake and flags load-after-store hazards.
module ysyx_22050078_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_st_valid,
    output logic                       o_st_ready,
    input  logic [63:0]                i_st_addr,
    input  logic [63:0]                i_st_data,
    input  logic [1:0]                 i_st_size,
    output logic                       o_st_misalign,
    input  logic                       i_ld_valid,
    input  logic [63:0]                i_ld_addr,
    output logic                       o_ld_hazard,
    output logic                       o_mem_wen,
    output logic [63:0]                o_mem_waddr,
    output logic [63:0]                o_mem_wdata,
    output logic [7:0]                 o_mem_wmask,
    input  logic                       i_mem_ready,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0][60:0] addr_q, addr_d;
    logic [DEPTH-1:0][63:0] data_q, data_d;
    logic [DEPTH-1:0][7:0]  mask_q, mask_d;
    logic [DEPTH-1:0]       valid_q, valid_d;
    logic [AW-1:0]          head_q, head_d;
    logic [AW-1:0]          tail_q, tail_d;
    logic [CW-1:0]          count_q, count_d;
    logic                   misalign_q, misalign_d;

    logic [2:0]  off;
    logic [7:0]  base;
    logic        aligned;
    logic [63:0] expand;
    logic [7:0]  enc_mask;
    logic [63:0] enc_data;
    logic        accept;
    logic        push;
    logic        pop;
    logic        hit;

    always_comb begin
        off     = i_st_addr[2:0];
        base    = 8'h01;
        aligned = 1'b1;
        unique case (i_st_size)
            2'd0: begin base = 8'h01; aligned = 1'b1; end
            2'd1: begin base = 8'h03; aligned = (off[0] == 1'b0); end
            2'd2: begin base = 8'h0f; aligned = (off[1:0] == 2'b00); end
            2'd3: begin base = 8'hff; aligned = (off == 3'b000); end
        endcase
        expand = '0;
        for (int b = 0; b < 8; b++) begin
            expand[8*b +: 8] = {8{base[b]}};
        end
        enc_mask = base << off;
        enc_data = (i_st_data & expand) << {off, 3'b000};
    end

    assign o_st_ready = !i_rst && (count_q < FULL);
    assign accept     = i_st_valid && o_st_ready;
    assign push       = accept && aligned;
    assign pop        = (count_q != '0) && i_mem_ready;

    // Push and pop never target the same slot: pop needs count>0, push count<DEPTH.
    always_comb begin
        addr_d     = addr_q;
        data_d     = data_q;
        mask_d     = mask_q;
        valid_d    = valid_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        misalign_d = accept && !aligned;
        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + AW'(1);
        end
        if (push) begin
            addr_d[tail_q]  = i_st_addr[63:3];
            data_d[tail_q]  = enc_data;
            mask_d[tail_q]  = enc_mask;
            valid_d[tail_q] = 1'b1;
            tail_d          = tail_q + AW'(1);
        end
        unique case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            valid_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            misalign_q <= 1'b0;
        end else begin
            valid_q    <= valid_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            misalign_q <= misalign_d;
        end
    end

    always_ff @(posedge i_clk) begin
        addr_q <= addr_d;
        data_q <= data_d;
        mask_q <= mask_d;
    end

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && (addr_q[i] == i_ld_addr[63:3])) begin
                hit = 1'b1;
            end
        end
    end

    assign o_ld_hazard   = i_ld_valid && hit;
    assign o_st_misalign = misalign_q;
    assign o_mem_wen     = (count_q != '0);
    assign o_mem_waddr   = {addr_q[head_q], 3'b000};
    assign o_mem_wdata   = data_q[head_q];
    assign o_mem_wmask   = mask_q[head_q];
    assign o_empty       = (count_q == '0);
    assign o_count       = count_q;

endmodule
